// File: rtl/argmax_stage.sv
// Sequential argmax over N IEEE-754 single-precision values, one compare per cycle.
// Optional macro ARGMAX_NAN_SKIP_EN: NaN elements are never selected as the maximum.
module argmax_stage #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 32
) (
    input  logic                                 CLK,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [W-1:0]                         inputs [0:N-1],
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] class_idx,
    output logic [W-1:0]                         max_val,
    output logic                                 busy,
    output logic                                 done
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_next;

    logic [W-1:0]   r_snap [0:N-1];
    logic [W-1:0]   r_best;
    logic [CW-1:0]  r_best_idx;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  r_class_idx;
    logic [W-1:0]   r_max_val;
    logic           r_done;

    logic [W-1:0]   w_cand;
    logic           w_gt;
    logic           w_take;
    logic           w_last;

    // Monotonic key: unsigned compare of keys matches float ordering, with -0 folded onto +0.
    function automatic logic [W-1:0] f_key(input logic [W-1:0] v);
        logic [W-1:0] c;
        c = (v[W-2:0] == '0) ? '0 : v;
        return c[W-1] ? ~c : {1'b1, c[W-2:0]};
    endfunction

`ifdef ARGMAX_NAN_SKIP_EN
    logic r_have;

    function automatic logic f_is_nan(input logic [W-1:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != '0);
    endfunction
`endif

    assign w_cand = r_snap[r_cnt];
    assign w_gt   = f_key(w_cand) > f_key(r_best);
    assign w_last = (r_cnt == CW'(N - 1));

`ifdef ARGMAX_NAN_SKIP_EN
    assign w_take = !f_is_nan(w_cand) && (!r_have || w_gt);
`else
    assign w_take = w_gt;
`endif

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (N == 1) ? S_DONE : S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < N; i++) begin
                r_snap[i] <= '0;
            end
            r_best      <= '0;
            r_best_idx  <= '0;
            r_cnt       <= '0;
            r_class_idx <= '0;
            r_max_val   <= '0;
            r_done      <= 1'b0;
`ifdef ARGMAX_NAN_SKIP_EN
            r_have      <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        for (int unsigned i = 0; i < N; i++) begin
                            r_snap[i] <= inputs[i];
                        end
                        r_best     <= inputs[0];
                        r_best_idx <= '0;
                        r_cnt      <= CW'(1);
`ifdef ARGMAX_NAN_SKIP_EN
                        // A NaN seed is provisional; the first non-NaN value replaces it.
                        r_have     <= !f_is_nan(inputs[0]);
`endif
                    end
                end
                S_SCAN: begin
                    if (w_take) begin
                        r_best     <= w_cand;
                        r_best_idx <= r_cnt;
`ifdef ARGMAX_NAN_SKIP_EN
                        r_have     <= 1'b1;
`endif
                    end
                    r_cnt <= r_cnt + CW'(1);
                end
                S_DONE: begin
                    r_done      <= 1'b1;
                    r_class_idx <= r_best_idx;
                    r_max_val   <= r_best;
                end
                default: ;
            endcase
        end
    end

    assign class_idx = r_class_idx;
    assign max_val   = r_max_val;
    assign done      = r_done;
    assign busy      = (r_state != S_IDLE);

endmodule
